fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the SimpleRISC pipeline.
- Owns the PC and drives the address port of InstructionMemory, a synchronous BRAM with 1-cycle read latency.
- Delivers instruction/PC pairs to the IF/OF pipeline latch over a valid/ready handshake.
- Supports a branch redirect from the execute stage and downstream stalls, using a one-entry skid register so no word is lost or duplicated.

Parameters:
- PC_W, 32, width of the byte-addressed PC.
- ADDR_W, 10, instruction-memory word-address width; addressable words = 2^ADDR_W.
- RESET_PC, 0, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  ADDR_W  word address to InstructionMemory; equals pc[ADDR_W+1:2].
- imem_dout  in  32  InstructionMemory read data, valid the cycle after the address is sampled.
- redirect_valid  in  1  taken branch/call/ret from EX.
- redirect_pc  in  PC_W  branch target (byte address; bits [1:0] ignored).
- out_ready  in  1  IF/OF latch can accept; low = stall.
- out_valid  out  1  out_instr/out_pc hold a valid fetched word.
- out_instr  out  32  fetched instruction.
- out_pc  out  PC_W  byte PC of out_instr.

Behaviour:
- Registers: pc, rd_valid/rd_pc (read in flight), skid_valid/skid_instr/skid_pc, out_valid/out_instr/out_pc.
- Reset (async, immediate):
  - pc=RESET_PC.
  - rd_valid, skid_valid, out_valid = 0.
  - out_instr=0, out_pc=0, skid contents=0.
- Issue:
  - issue = !out_valid || out_ready, and no redirect this cycle.
  - On issue at an edge: rd_valid<=1, rd_pc<=pc, pc<=pc+4 (mod 2^PC_W). Otherwise rd_valid<=0 and pc holds.
- Arrival:
  - If rd_valid, word imem_dout with PC rd_pc arrives this cycle.
- Output stage is free when !out_valid || out_ready. If free:
  - skid_valid: out <= skid, skid_valid<=0.
  - else arrival: out <= arrival.
  - else: out_valid<=0.
- If the output stage is not free and a word arrives: skid <= arrival, skid_valid<=1.
- Invariant: arrival and skid_valid=1 never coincide. Issue is blocked in every cycle the skid fills, so no read is in flight. A bench assertion checks this.
- Transfer completes when out_valid && out_ready at an edge.
- Redirect has priority over everything, including a stall:
  - pc <= {redirect_pc[PC_W-1:2],2'b00}.
  - rd_valid, skid_valid, out_valid <= 0.
  - The in-flight BRAM word is discarded.
- Redirect latency: redirect at edge E → issue at E+1 → target word has out_valid=1 after E+2, i.e. 2 bubble cycles. No pre-redirect word appears after E.
- Throughput: with out_ready held high, one word per cycle.
- Memory wrap: imem_addr uses pc[ADDR_W+1:2] only. Addresses alias mod 2^ADDR_W words while pc/out_pc keep counting. PC wraps mod 2^PC_W.
- Stalls: out_instr/out_pc/out_valid are stable while out_valid && !out_ready, unless a redirect occurs.
- Reset mid-operation: all valids drop asynchronously. The first issue is from RESET_PC at the first edge after rst deasserts.

Decomposition:
- Shared package fetch_pkg:
  - INSTR_W=32
  - PC_STEP=4
  - NOP encoding (SimpleRISC nop, 0x68000000) for the OF stage's bubble insertion
- Sub-module fetch_skid_buffer: one-entry {instr,pc} register with load/unload/flush. Used for the skid; the output register may reuse it.
- PC and issue logic stay in fetch_unit.

Test Plan:
All tests preload mem[i]=0xA000_0000+i.
1. Reset released, out_ready=1: first out_valid after 2nd edge with out_instr=0xA0000000, out_pc=0. Then 0xA0000001/4, 0xA0000002/8 … one per cycle.
2. Streaming, then out_ready=0 for 5 cycles while out shows pc 0x8: outputs hold 0xA0000002/0x8, skid captures 0xA0000003. On release the sequence continues 0x8, 0xC, 0x10 with no gap-induced loss or duplicates.
3. redirect_valid=1, redirect_pc=0x40 mid-stream: out_valid=0 for 2 cycles, then 0xA0000010/0x40, 0xA0000011/0x44. No older word is observed.
4. Redirect to 0x43 asserted while out_ready=0 and skid full: all flushed. After out_ready=1, the first word is 0xA0000010 with out_pc=0x40 (low bits cleared).
5. ADDR_W=3, redirect to 0x1C: words 0xA0000007/0x1C, 0xA0000000/0x20, 0xA0000001/0x24 (address aliases, PC continues).
6. rst pulsed between edges mid-stream: out_valid falls before the next edge. After release, the stream restarts at RESET_PC with the test-1 timing.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the SimpleRISC instruction-fetch stage.
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  // SimpleRISC nop; the OF stage inserts it when fetch presents a bubble.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h6800_0000;

  typedef logic [INSTR_W-1:0] instr_t;
endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc} holding register with load, unload and flush.
module fetch_skid_buffer
  import fetch_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            load,
  input  logic            unload,
  input  instr_t          in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            valid,
  output instr_t          instr,
  output logic [PC_W-1:0] pc
);

  logic            valid_q, valid_d;
  instr_t          instr_q, instr_d;
  logic [PC_W-1:0] pc_q, pc_d;

  // Flush beats load, load beats unload; contents hold when the entry empties.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = in_instr;
      pc_d    = in_pc;
    end else if (unload) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// SimpleRISC fetch stage: PC, BRAM address issue, skid and output register
// feeding the IF/OF latch over valid/ready, with branch redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              ADDR_W   = 10,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  instr_t            imem_dout,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              out_ready,
  output logic              out_valid,
  output instr_t            out_instr,
  output logic [PC_W-1:0]   out_pc
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] rd_pc_q, rd_pc_d;
  logic            rd_valid_q, rd_valid_d;

  logic            stage_free, issue, arrival;
  logic            skid_valid;
  instr_t          skid_instr;
  logic [PC_W-1:0] skid_pc;
  logic            skid_load, skid_unload, out_load, out_unload;
  instr_t          out_src_instr;
  logic [PC_W-1:0] out_src_pc;

  assign imem_addr = pc_q[ADDR_W+1:2];

  always_comb begin
    stage_free = !out_valid || out_ready;
    arrival    = rd_valid_q;
    issue      = stage_free && !redirect_valid;

    pc_d       = pc_q;
    rd_pc_d    = rd_pc_q;
    rd_valid_d = 1'b0;
    if (redirect_valid) begin
      pc_d = redirect_pc & ~PC_W'(PC_STEP - 1);
    end else if (issue) begin
      rd_valid_d = 1'b1;
      rd_pc_d    = pc_q;
      pc_d       = pc_q + PC_W'(PC_STEP);
    end

    // A word landing while the output is blocked parks in the skid; issue is
    // suppressed that same cycle, so the skid never meets a fresh arrival.
    skid_load   = !redirect_valid && !stage_free && arrival;
    skid_unload = !redirect_valid && stage_free && skid_valid;
    out_load    = !redirect_valid && stage_free && (skid_valid || arrival);
    out_unload  = stage_free;

    out_src_instr = skid_valid ? skid_instr : imem_dout;
    out_src_pc    = skid_valid ? skid_pc    : rd_pc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      rd_pc_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      rd_pc_q    <= rd_pc_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  fetch_skid_buffer #(.PC_W(PC_W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .load     (skid_load),
    .unload   (skid_unload),
    .in_instr (imem_dout),
    .in_pc    (rd_pc_q),
    .valid    (skid_valid),
    .instr    (skid_instr),
    .pc       (skid_pc)
  );

  fetch_skid_buffer #(.PC_W(PC_W)) u_out (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .load     (out_load),
    .unload   (out_unload),
    .in_instr (out_src_instr),
    .in_pc    (out_src_pc),
    .valid    (out_valid),
    .instr    (out_instr),
    .pc       (out_pc)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 10-bit-address instance plus a 3-bit one
// that shows address aliasing, each with its own synchronous BRAM model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_ready = 1'b1;

  logic [9:0]  imem_addr;
  logic [31:0] imem_dout;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  logic [2:0]  imem_addr3;
  logic [31:0] imem_dout3;
  logic        out_valid3;
  logic [31:0] out_instr3;
  logic [31:0] out_pc3;

  logic [31:0] mem  [1024];
  logic [31:0] mem3 [8];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + i;
    for (int i = 0; i < 8; i++)    mem3[i] = 32'hA000_0000 + i;
  end

  always @(posedge clk) imem_dout  <= mem[imem_addr];
  always @(posedge clk) imem_dout3 <= mem3[imem_addr3];

  fetch_unit #(.PC_W(32), .ADDR_W(10), .RESET_PC(32'd0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_dout      (imem_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  fetch_unit #(.PC_W(32), .ADDR_W(3), .RESET_PC(32'd0)) dut3 (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr3),
    .imem_dout      (imem_dout3),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_ready      (out_ready),
    .out_valid      (out_valid3),
    .out_instr      (out_instr3),
    .out_pc         (out_pc3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input string tag, input logic [31:0] instr, input logic [31:0] pc);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_instr"}, out_instr, instr);
    check({tag, "_pc"}, out_pc, pc);
  endtask

  task automatic expect_word3(input string tag, input logic [31:0] instr, input logic [31:0] pc);
    check({tag, "_valid3"}, {31'd0, out_valid3}, 32'd1);
    check({tag, "_instr3"}, out_instr3, instr);
    check({tag, "_pc3"}, out_pc3, pc);
  endtask

  task automatic expect_bubble(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A word may never land while the skid is already occupied.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert (!(dut.rd_valid_q && dut.skid_valid)) else begin
        errors++;
        $error("FAIL skid_arrival_overlap: observed rd_valid=%0b skid_valid=%0b expected not both",
               dut.rd_valid_q, dut.skid_valid);
      end
    end
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr", out_instr, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_addr", {22'd0, imem_addr}, 32'd0);
    #2 rst = 1'b0;

    // Test 1: stream from reset, one word per cycle
    tick();
    expect_bubble("t1_e1");
    tick();
    expect_word("t1_e2", 32'hA000_0000, 32'h0);
    tick();
    expect_word("t1_e3", 32'hA000_0001, 32'h4);
    tick();
    expect_word("t1_e4", 32'hA000_0002, 32'h8);

    // Test 2: five stall cycles hold the output, skid keeps the next word
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_word("t2_hold", 32'hA000_0002, 32'h8);
      check("t2_addr_hold", {22'd0, imem_addr}, 32'd4);
    end
    out_ready = 1'b1;
    tick();
    expect_word("t2_skid", 32'hA000_0003, 32'hC);
    tick();
    expect_word("t2_next", 32'hA000_0004, 32'h10);
    tick();
    expect_word("t2_next2", 32'hA000_0005, 32'h14);

    // Test 3: redirect mid-stream, two bubbles then the target
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    expect_bubble("t3_b1");
    tick();
    expect_bubble("t3_b2");
    tick();
    expect_word("t3_tgt", 32'hA000_0010, 32'h40);
    tick();
    expect_word("t3_tgt1", 32'hA000_0011, 32'h44);

    // Test 4: redirect to unaligned 0x43 while stalled with the skid full
    out_ready = 1'b0;
    tick();
    expect_word("t4_stall", 32'hA000_0011, 32'h44);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    expect_bubble("t4_flush");
    tick();
    expect_bubble("t4_b2");
    tick();
    expect_word("t4_tgt", 32'hA000_0010, 32'h40);
    tick();
    expect_word("t4_tgt1", 32'hA000_0011, 32'h44);

    // Test 5: ADDR_W=3 aliasing after redirect to 0x1C
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1C;
    tick();
    redirect_valid = 1'b0;
    check("t5_flush_valid3", {31'd0, out_valid3}, 32'd0);
    tick();
    check("t5_b2_valid3", {31'd0, out_valid3}, 32'd0);
    tick();
    expect_word3("t5_w0", 32'hA000_0007, 32'h1C);
    expect_word("t5_wide0", 32'hA000_0007, 32'h1C);
    tick();
    expect_word3("t5_w1", 32'hA000_0000, 32'h20);
    expect_word("t5_wide1", 32'hA000_0008, 32'h20);
    tick();
    expect_word3("t5_w2", 32'hA000_0001, 32'h24);

    // Test 6: asynchronous reset pulse between edges
    #2 rst = 1'b1;
    #1;
    check("t6_async_valid", {31'd0, out_valid}, 32'd0);
    check("t6_async_valid3", {31'd0, out_valid3}, 32'd0);
    check("t6_async_instr", out_instr, 32'd0);
    check("t6_async_pc", out_pc, 32'd0);
    #2 rst = 1'b0;
    tick();
    expect_bubble("t6_e1");
    tick();
    expect_word("t6_e2", 32'hA000_0000, 32'h0);
    expect_word3("t6_e2", 32'hA000_0000, 32'h0);
    tick();
    expect_word("t6_e3", 32'hA000_0001, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
